// File: rtl/data_ready_gate_gen.sv
// data_ready_gate_gen: per-channel trigger -> programmable delay -> programmable-width gate.
// Revision: 1.0 - initial multi-channel release.
`default_nettype none

module data_ready_gate_gen #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   trig,
  input  logic [NCH-1:0]   abort,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic             retrig_en,
  input  logic             ovr_clr,
  output logic [NCH-1:0]   gate_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_GATE  = 2'd2
  } state_t;

  // A zero width still yields a one-clock gate.
  logic [CNT_W-1:0] width_eff;
  assign width_eff = (width_cfg == '0) ? CNT_W'(1) : width_cfg;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] wlat;
    logic [CNT_W-1:0] wlat_nxt;
    logic             done_r;
    logic             done_nxt;
    logic             ovr_r;
    logic             ovr_nxt;
    logic             accept;

    // A trigger is taken from IDLE, or while busy when retriggering is enabled.
    assign accept = trig[g] && ((state == S_IDLE) || retrig_en);

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wlat_nxt  = wlat;
      done_nxt  = 1'b0;
      ovr_nxt   = ovr_r;
      if (ovr_clr) begin
        ovr_nxt = 1'b0;
      end
      if (abort[g]) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else if (accept) begin
        wlat_nxt = width_eff;
        if (delay_cfg == '0) begin
          state_nxt = S_GATE;
          cnt_nxt   = width_eff - 1'b1;
        end else begin
          state_nxt = S_DELAY;
          cnt_nxt   = delay_cfg - 1'b1;
        end
      end else begin
        // Busy and not retriggerable: the trigger is dropped and flagged.
        if (trig[g]) begin
          ovr_nxt = 1'b1;
        end
        case (state)
          S_DELAY: begin
            if (cnt == '0) begin
              state_nxt = S_GATE;
              cnt_nxt   = wlat - 1'b1;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
          S_GATE: begin
            if (cnt == '0) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= S_IDLE;
        cnt    <= '0;
        wlat   <= '0;
        done_r <= 1'b0;
        ovr_r  <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        wlat   <= wlat_nxt;
        done_r <= done_nxt;
        ovr_r  <= ovr_nxt;
      end
    end

    assign gate_out[g] = (state == S_GATE);
    assign busy[g]     = (state != S_IDLE);
    assign done[g]     = done_r;
    assign overrun[g]  = ovr_r;
  end

endmodule

`default_nettype wire
